// File: rtl/apb_slave_regfile_param_pkg.sv
// Shared types and constants for the parametrised APB register-file slave.
package apb_slave_regfile_param_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_WAIT   = 3'b010,
    ST_ACCESS = 3'b100
  } state_e;

  localparam logic [7:0]  SYS_STATUS_REG  = 8'h00;
  localparam logic [7:0]  SYS_CFG_REG     = 8'h04;
  localparam logic [7:0]  DEV_ID_REG      = 8'h08;
  localparam logic [7:0]  SYS_CTRL_REG    = 8'h0C;

  localparam logic [15:0] DEFAULT_RO_MASK = 16'h0005;
  localparam int          MAX_WAIT_STATES = 15;

endpackage

// File: rtl/apb_slave_regfile_param_bank.sv
// RW register array with byte-strobe writes and a one-cycle write pulse per register.
module apb_slave_regfile_param_bank #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_REGS)-1:0]    wr_idx,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    if (wr_en && !RO_MASK[wr_idx]) begin
      wr_pulse_d[wr_idx] = 1'b1;
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wr_strb[b]) regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // Read-only slots are never written; their output slice is tied to zero.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
  end

  assign wr_pulse = wr_pulse_q;

endmodule

// File: rtl/apb_slave_regfile_param.sv
// APB4 slave front end: address decode, wait-state FSM and read mux over the register bank.
//   state     | meaning
//   ST_IDLE   | no transfer; waits for a setup phase, PRDATA/PSLVERR held at 0
//   ST_WAIT   | wait states counting down, PREADY=0
//   ST_ACCESS | PREADY=1; write commits on PSEL&PENABLE
module apb_slave_regfile_param
  import apb_slave_regfile_param_pkg::*;
#(
  parameter int                  DATA_WIDTH  = 32,
  parameter int                  ADDR_WIDTH  = 32,
  parameter int                  NUM_REGS    = 16,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = NUM_REGS'(DEFAULT_RO_MASK),
  localparam int                 STRB_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [STRB_WIDTH-1:0]          PSTRB,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [3:0] WAIT_LOAD =
    4'((WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;

  logic [IDX_W-1:0]      idx;
  logic                  addr_bad, err, wr_en;
  logic [DATA_WIDTH-1:0] rd_val;

  assign idx      = PADDR[LSB +: IDX_W];
  assign addr_bad = (PADDR >= ADDR_WIDTH'(NUM_REGS * STRB_WIDTH)) ||
                    (|(PADDR & ADDR_WIDTH'(STRB_WIDTH - 1)));
  assign err      = addr_bad || (PWRITE && RO_MASK[idx]);
  assign rd_val   = RO_MASK[idx] ? hw_in[idx*DATA_WIDTH +: DATA_WIDTH]
                                 : reg_out[idx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    err_d     = err_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    wr_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        prdata_d  = '0;
        pslverr_d = 1'b0;
        if (PSEL && !PENABLE) begin
          idx_d     = idx;
          write_d   = PWRITE;
          wdata_d   = PWDATA;
          strb_d    = PSTRB;
          err_d     = err;
          prdata_d  = (!PWRITE && !err) ? rd_val : '0;
          pslverr_d = err;
          cnt_d     = WAIT_LOAD;
          state_d   = (WAIT_LOAD == 4'd0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          state_d   = ST_IDLE;
          prdata_d  = '0;
          pslverr_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!PSEL || PENABLE) begin
          // A dropped PSEL is a master abort: leave without committing.
          wr_en     = PSEL && write_q && !err_q;
          state_d   = ST_IDLE;
          prdata_d  = '0;
          pslverr_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        prdata_d  = '0;
        pslverr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign PREADY  = (state_q == ST_ACCESS);
  assign PRDATA  = prdata_q;
  assign PSLVERR = pslverr_q;

  apb_slave_regfile_param_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK)
  ) u_bank (
    .clk      (PCLK),
    .rst      (PRESET),
    .wr_en    (wr_en),
    .wr_idx   (idx_q),
    .wr_data  (wdata_q),
    .wr_strb  (strb_q),
    .reg_out  (reg_out),
    .wr_pulse (wr_pulse)
  );

endmodule

// File: tb/tb_apb_slave_regfile_param.sv
// Self-checking bench: a zero-wait and a three-wait instance against an array model of the register map.
module tb_apb_slave_regfile_param;

  localparam logic [15:0] RO = 16'h0005;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         psel0 = 1'b0, psel1 = 1'b0;
  logic         penable = 1'b0, pwrite = 1'b0;
  logic [31:0]  paddr = '0, pwdata = '0;
  logic [3:0]   pstrb = '0;
  logic [511:0] hw_in = '0;
  logic [31:0]  prdata0, prdata1;
  logic         pready0, pready1, pslverr0, pslverr1;
  logic [511:0] reg_out0, reg_out1;
  logic [15:0]  wr_pulse0, wr_pulse1;

  int checks = 0;
  int failures = 0;
  bit [31:0] model [2][16];

  always #5 clk = ~clk;

  apb_slave_regfile_param #(.WAIT_STATES(0)) dut0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata0), .PREADY(pready0),
    .PSLVERR(pslverr0), .hw_in(hw_in), .reg_out(reg_out0), .wr_pulse(wr_pulse0));

  apb_slave_regfile_param #(.WAIT_STATES(3)) dut1 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata1), .PREADY(pready1),
    .PSLVERR(pslverr1), .hw_in(hw_in), .reg_out(reg_out1), .wr_pulse(wr_pulse1));

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic        rdy(input int d);  return d == 0 ? pready0 : pready1;     endfunction
  function automatic logic [31:0] rdat(input int d); return d == 0 ? prdata0 : prdata1;     endfunction
  function automatic logic        serr(input int d); return d == 0 ? pslverr0 : pslverr1;   endfunction
  function automatic logic [15:0] puls(input int d); return d == 0 ? wr_pulse0 : wr_pulse1; endfunction
  function automatic logic [511:0] rout(input int d); return d == 0 ? reg_out0 : reg_out1;  endfunction

  function automatic logic [511:0] exp_regout(input int d);
    logic [511:0] v = '0;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = RO[i] ? 32'h0 : model[d][i];
    return v;
  endfunction

  task automatic randomize_hw();
    for (int i = 0; i < 16; i++) hw_in[i*32 +: 32] = $urandom();
  endtask

  task automatic set_psel(input int d, input logic v);
    if (d == 0) psel0 = v; else psel1 = v;
  endtask

  // One complete APB transfer, compared against the model's expectations.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input bit scramble, input string tag);
    int          idx = int'(addr[5:2]);
    bit          err = (addr >= 32'd64) || (addr % 4 != 0) || (wr && RO[idx]);
    logic [31:0] exp_rd = (!wr && !err) ? (RO[idx] ? hw_in[idx*32 +: 32] : model[d][idx]) : 32'h0;
    logic [15:0] exp_pulse = (wr && !err) ? (16'h1 << idx) : 16'h0;
    int          waits = 0;
    if (wr && !err)
      for (int b = 0; b < 4; b++) if (strb[b]) model[d][idx][8*b +: 8] = data[8*b +: 8];
    @(posedge clk); #1;
    set_psel(d, 1'b1); penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    if (scramble) randomize_hw();
    while (!rdy(d) && waits < 40) begin
      @(posedge clk); #1;
      waits++;
    end
    check({tag, ".waits"}, waits, (d == 0) ? 0 : 3);
    check({tag, ".rdata"}, rdat(d), exp_rd);
    check({tag, ".slverr"}, serr(d), err);
    @(posedge clk); #1;
    set_psel(d, 1'b0); penable = 1'b0;
    check({tag, ".pulse"}, puls(d), exp_pulse);
    check({tag, ".reg_out"}, rout(d), exp_regout(d));
    @(posedge clk); #1;
    check({tag, ".pulse_gone"}, puls(d), 16'h0);
    check({tag, ".idle_rdata"}, {rdat(d), serr(d)}, 33'h0);
  endtask

  initial begin
    int          w;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) model[d][i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset.ready", {pready0, pready1}, 2'b00);
    check("reset.rdata", {prdata0, prdata1, pslverr0, pslverr1}, 66'h0);
    check("reset.pulse", {wr_pulse0, wr_pulse1}, 32'h0);
    check("reset.regs", {reg_out0, reg_out1}, 1024'h0);
    rst = 1'b0;

    xfer(0, 1, 32'h04, 32'hDEADBEEF, 4'hF, 0, "ws0_wr04");
    xfer(0, 0, 32'h04, 32'h0, 4'h0, 0, "ws0_rd04");
    xfer(1, 1, 32'h0C, 32'hCAFE0123, 4'hF, 0, "ws3_wr0c");
    xfer(1, 0, 32'h0C, 32'h0, 4'h0, 0, "ws3_rd0c");

    xfer(0, 1, 32'h10, 32'hFFFFFFFF, 4'hF, 0, "strb_fill");
    xfer(0, 1, 32'h10, 32'h12345678, 4'b0101, 0, "strb_0101");
    xfer(0, 0, 32'h10, 32'h0, 4'h0, 0, "strb_rd");
    check("strb_value", model[0][4], 32'hFF34FF78);
    xfer(0, 1, 32'h10, 32'h0BADF00D, 4'h0, 0, "strb_none");

    xfer(0, 1, 32'h08, 32'h11111111, 4'hF, 0, "err_ro");
    xfer(0, 1, 32'h40, 32'h22222222, 4'hF, 0, "err_range");
    xfer(0, 1, 32'h06, 32'h33333333, 4'hF, 0, "err_align");
    xfer(0, 0, 32'h41, 32'h0, 4'h0, 0, "err_rd_range");
    hw_in[2*32 +: 32] = 32'hA5A5_0001;
    xfer(0, 0, 32'h08, 32'h0, 4'h0, 0, "ro_rd08");
    xfer(1, 0, 32'h00, 32'h0, 4'h0, 1, "ro_rd00_scramble");

    // Master abort: PSEL dropped during a wait state of a write.
    @(posedge clk); #1;
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1C; pwdata = 32'h5555AAAA; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel1 = 1'b0; penable = 1'b0;
    w = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (pready1 || wr_pulse1 != 0) w++;
    end
    check("abort.quiet", w, 0);
    check("abort.reg", reg_out1, exp_regout(1));
    xfer(1, 0, 32'h1C, 32'h0, 4'h0, 0, "abort_next_rd");
    xfer(1, 1, 32'h1C, 32'h76543210, 4'hF, 0, "abort_next_wr");

    for (int n = 0; n < 60; n++) begin
      int  d = n % 2;
      int  kind = $urandom_range(0, 9);
      int  idx = $urandom_range(0, 15);
      bit  wr = $urandom_range(0, 1) == 1;
      if (kind == 0)      a = 32'd64 + 32'(4 * $urandom_range(0, 15));
      else if (kind == 1) a = 32'(idx * 4 + $urandom_range(1, 3));
      else                a = 32'(idx * 4);
      if (n % 7 == 0) randomize_hw();
      xfer(d, wr, a, $urandom(), 4'($urandom_range(0, 15)), (n % 5 == 0), $sformatf("rnd%0d", n));
    end

    // Asynchronous reset while the three-wait instance sits in its access cycle.
    @(posedge clk); #1;
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'h9999_7777; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    w = 0;
    while (!pready1 && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    check("rst_mid.reached_access", {w, pready1}, {32'd3, 1'b1});
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) model[d][i] = '0;
    check("rst_mid.ready", pready1, 1'b0);
    check("rst_mid.rdata", {prdata1, pslverr1}, 33'h0);
    check("rst_mid.pulse", wr_pulse1, 16'h0);
    check("rst_mid.regs1", reg_out1, exp_regout(1));
    check("rst_mid.regs0", reg_out0, exp_regout(0));
    @(posedge clk); #1;
    psel1 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid.no_write", reg_out1, exp_regout(1));
    xfer(1, 0, 32'h14, 32'h0, 4'h0, 0, "post_rst_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
